alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_op_decode.sv | 23 ++
 rtl/alu_cmd_seq.sv | 132 +++++++++++++
 tb/tb_alu_cmd_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: op codes, one-hot ALU selects,
// ALU state codes and the sequencer FSM encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_XOR  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_MULT = 3'd6,
        OP_CLR  = 3'd7
    } aluOp_t;

    localparam logic [2:0] IN_RESET   = 3'b001;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_PERSIST = 3'b100;

    localparam logic [6:0] OUT_AND  = 7'b0000001;
    localparam logic [6:0] OUT_OR   = 7'b0000010;
    localparam logic [6:0] OUT_NOT  = 7'b0000100;
    localparam logic [6:0] OUT_XOR  = 7'b0001000;
    localparam logic [6:0] OUT_ADD  = 7'b0010000;
    localparam logic [6:0] OUT_SUB  = 7'b0100000;
    localparam logic [6:0] OUT_MULT = 7'b1000000;

    localparam logic [1:0] ALU_OFF     = 2'b00;
    localparam logic [1:0] ALU_READY   = 2'b01;
    localparam logic [1:0] ALU_RUN     = 2'b10;
    localparam logic [1:0] ALU_RUN_ERR = 2'b11;

    typedef enum logic [2:0] {
        WARM  = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        EXEC  = 3'd3,
        CHECK = 3'd4,
        RESP  = 3'd5
    } seqState_t;

endpackage

// File: rtl/alu_op_decode.sv
// Maps a 3-bit command op onto the ALU's one-hot output select; CLR reads back through AND.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] op,
    output logic [6:0] outSel
);

    always_comb begin
        outSel = OUT_AND;
        case (op)
            OP_AND:  outSel = OUT_AND;
            OP_OR:   outSel = OUT_OR;
            OP_NOT:  outSel = OUT_NOT;
            OP_XOR:  outSel = OUT_XOR;
            OP_ADD:  outSel = OUT_ADD;
            OP_SUB:  outSel = OUT_SUB;
            OP_MULT: outSel = OUT_MULT;
            default: outSel = OUT_AND;
        endcase
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer driving an external accumulator ALU with a fixed-latency response.
// Define ALU_SEQ_ERRCNT_EN to build the saturating error-response counter.
module alu_cmd_seq
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_load,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       alu_on,
    output logic [2:0] alu_in_sel,
    output logic [6:0] alu_out_sel,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    input  logic [7:0] alu_result,
    input  logic [1:0] alu_state,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] err_count
);

    seqState_t  state;
    logic [2:0] opReg;
    logic [6:0] decodedSel;

    alu_op_decode opDecode (
        .op     (opReg),
        .outSel (decodedSel)
    );

    // Outputs are registered on the edge that enters the state they belong to,
    // so the ALU sees each state's drive values for that whole state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WARM;
            opReg       <= OP_AND;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_err     <= 1'b0;
            alu_on      <= 1'b0;
            alu_in_sel  <= IN_RESET;
            alu_out_sel <= OUT_AND;
            alu_num1    <= 8'h00;
            alu_num2    <= 8'hFF;
        end else begin
            case (state)
                WARM: begin
                    alu_on     <= 1'b1;
                    alu_in_sel <= IN_RESET;
                    if (alu_state == ALU_READY) begin
                        state       <= IDLE;
                        alu_in_sel  <= IN_PERSIST;
                        alu_out_sel <= OUT_AND;
                        alu_num2    <= 8'hFF;
                        cmd_ready   <= 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state       <= ISSUE;
                        opReg       <= cmd_op;
                        cmd_ready   <= 1'b0;
                        alu_out_sel <= OUT_AND;
                        alu_num1    <= cmd_a;
                        alu_num2    <= cmd_b;
                        if (cmd_op == OP_CLR)
                            alu_in_sel <= IN_RESET;
                        else if (cmd_load)
                            alu_in_sel <= IN_LOAD;
                        else
                            alu_in_sel <= IN_PERSIST;
                    end
                end
                ISSUE: begin
                    state       <= EXEC;
                    alu_in_sel  <= IN_PERSIST;
                    alu_num2    <= 8'hFF;
                    alu_out_sel <= decodedSel;
                end
                EXEC: begin
                    state       <= CHECK;
                    rsp_data    <= alu_result;
                    alu_in_sel  <= IN_PERSIST;
                    alu_out_sel <= OUT_AND;
                    alu_num2    <= 8'hFF;
                end
                CHECK: begin
                    state   <= RESP;
                    rsp_err <= (alu_state == ALU_RUN_ERR);
                end
                RESP: begin
                    // One settling cycle before rsp_valid keeps the latency at four edges.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= WARM;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ERRCNT_EN
    logic [7:0] errCount;

    // Counts handshaken error responses, sticking at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errCount <= 8'h00;
        end else if (state == RESP && rsp_valid && rsp_ready && rsp_err && errCount != 8'hFF) begin
            errCount <= errCount + 8'h01;
        end
    end

    assign err_count = errCount;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq with a small behavioural accumulator ALU attached.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_load;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       alu_on;
    logic [2:0] alu_in_sel;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_num1;
    logic [7:0] alu_num2;
    logic [7:0] alu_result;
    logic [1:0] alu_state;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] err_count;

    int assertCount = 0;
    int failCount   = 0;

    alu_cmd_seq dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_load    (cmd_load),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .alu_on      (alu_on),
        .alu_in_sel  (alu_in_sel),
        .alu_out_sel (alu_out_sel),
        .alu_num1    (alu_num1),
        .alu_num2    (alu_num2),
        .alu_result  (alu_result),
        .alu_state   (alu_state),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Accumulator ALU: result = acc <op> latched operand; persist feeds the result back.
    logic [7:0]  accReg  = 8'h00;
    logic [7:0]  bReg    = 8'hFF;
    logic        errFlag = 1'b0;
    logic [1:0]  warmCnt = 2'd0;
    logic [15:0] wide;

    always_comb begin
        wide = 16'h0000;
        case (alu_out_sel)
            OUT_AND:  wide = {8'h00, accReg & bReg};
            OUT_OR:   wide = {8'h00, accReg | bReg};
            OUT_NOT:  wide = {8'h00, ~accReg};
            OUT_XOR:  wide = {8'h00, accReg ^ bReg};
            OUT_ADD:  wide = {8'h00, accReg} + {8'h00, bReg};
            OUT_SUB:  wide = {8'h00, accReg} - {8'h00, bReg};
            OUT_MULT: wide = {8'h00, accReg} * {8'h00, bReg};
            default:  wide = 16'h0000;
        endcase
    end

    assign alu_result = wide[7:0];
    assign alu_state  = !alu_on          ? ALU_OFF :
                        (warmCnt != 2'd3) ? ALU_OFF :
                        errFlag           ? ALU_RUN_ERR :
                        (alu_out_sel == OUT_AND) ? ALU_READY : ALU_RUN;

    always_ff @(posedge clk) begin
        if (!alu_on) begin
            warmCnt <= 2'd0;
            errFlag <= 1'b0;
        end else begin
            if (warmCnt != 2'd3) warmCnt <= warmCnt + 2'd1;
            errFlag <= |wide[15:8];
            bReg    <= alu_num2;
            case (alu_in_sel)
                IN_RESET: accReg <= 8'h00;
                IN_LOAD:  accReg <= alu_num1;
                default:  accReg <= alu_result;
            endcase
        end
    end

    typedef struct {
        logic [2:0] op;
        logic       load;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expData;
        logic       expErr;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " cmd_ready"},   32'(cmd_ready),   0);
        checkOutput({tag, " rsp_valid"},   32'(rsp_valid),   0);
        checkOutput({tag, " rsp_data"},    32'(rsp_data),    0);
        checkOutput({tag, " rsp_err"},     32'(rsp_err),     0);
        checkOutput({tag, " alu_on"},      32'(alu_on),      0);
        checkOutput({tag, " alu_in_sel"},  32'(alu_in_sel),  32'h1);
        checkOutput({tag, " alu_out_sel"}, 32'(alu_out_sel), 32'h1);
        checkOutput({tag, " alu_num1"},    32'(alu_num1),    0);
        checkOutput({tag, " alu_num2"},    32'(alu_num2),    32'hFF);
        checkOutput({tag, " err_count"},   32'(err_count),   0);
    endtask

    // Presents one command, waits for acceptance, then counts edges until rsp_valid.
    task automatic applyStimulus(input logic [2:0] op, input logic load, input logic [7:0] a,
                                 input logic [7:0] b, output int lat);
        bit accepted = 0;
        cmd_op = op; cmd_load = load; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1;
                break;
            end
        end
        checkOutput("cmd accepted", 32'(accepted), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!rsp_valid && lat < 20);
    endtask

    initial begin
        int lat;
        int expErrCnt = 0;
        bit sawValid;
        bit gotReady;

        vecs[0] = '{OP_ADD,  1'b1, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[1] = '{OP_SUB,  1'b0, 8'h00, 8'h06, 8'h40, 1'b0};
        vecs[2] = '{OP_XOR,  1'b0, 8'h00, 8'hFF, 8'hBF, 1'b0};
        vecs[3] = '{OP_MULT, 1'b1, 8'h20, 8'h10, 8'h00, 1'b1};
        vecs[4] = '{OP_CLR,  1'b1, 8'h77, 8'h55, 8'h00, 1'b0};
        vecs[5] = '{OP_OR,   1'b0, 8'h00, 8'h0F, 8'h0F, 1'b0};
        vecs[6] = '{OP_NOT,  1'b1, 8'h5A, 8'h33, 8'hA5, 1'b0};
        vecs[7] = '{OP_ADD,  1'b0, 8'h00, 8'h60, 8'h05, 1'b1};
        vecs[8] = '{OP_SUB,  1'b1, 8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[9] = '{OP_AND,  1'b1, 8'hF0, 8'h3C, 8'h30, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_load = 1'b0;
        cmd_a = 8'h00; cmd_b = 8'h00; rsp_ready = 1'b1;
        #2 checkResetOutputs("reset");
        #10 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].load, vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d latency", i), lat, 4);
            checkOutput($sformatf("vec%0d rsp_data", i), 32'(rsp_data), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].expErr));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d rsp_valid drop", i), 32'(rsp_valid), 0);
`ifdef ALU_SEQ_ERRCNT_EN
            if (vecs[i].expErr) expErrCnt++;
`endif
            checkOutput($sformatf("vec%0d err_count", i), 32'(err_count), expErrCnt);
        end

        // Back-pressure: response held for three cycles while the next command queues.
        rsp_ready = 1'b0;
        applyStimulus(OP_OR, 1'b1, 8'h81, 8'h02, lat);
        checkOutput("stall latency", lat, 4);
        cmd_op = OP_XOR; cmd_load = 1'b0; cmd_a = 8'h00; cmd_b = 8'hFF; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 1);
            checkOutput($sformatf("stall%0d rsp_data", i), 32'(rsp_data), 32'h83);
            checkOutput($sformatf("stall%0d rsp_err", i), 32'(rsp_err), 0);
            checkOutput($sformatf("stall%0d cmd_ready", i), 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("handshake rsp_valid", 32'(rsp_valid), 0);
        checkOutput("handshake cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        checkOutput("queued accepted", 32'(cmd_ready), 0);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!rsp_valid && lat < 20);
        checkOutput("queued latency", lat, 4);
        checkOutput("queued rsp_data", 32'(rsp_data), 32'h7C);
        @(posedge clk);
        #1;

        // Reset during EXEC abandons the command and re-runs the warm-up.
        cmd_op = OP_ADD; cmd_load = 1'b1; cmd_a = 8'h03; cmd_b = 8'h04; cmd_valid = 1'b1;
        gotReady = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                gotReady = 1;
                break;
            end
        end
        checkOutput("pre-reset accept", 32'(gotReady), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 checkResetOutputs("midexec");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 0;
        gotReady = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) sawValid = 1;
            if (cmd_ready) begin
                gotReady = 1;
                break;
            end
        end
        checkOutput("no rsp after reset", 32'(sawValid), 0);
        checkOutput("ready after warm", 32'(gotReady), 1);
        applyStimulus(OP_ADD, 1'b1, 8'h03, 8'h04, lat);
        checkOutput("post-reset latency", lat, 4);
        checkOutput("post-reset rsp_data", 32'(rsp_data), 32'h07);
        checkOutput("post-reset rsp_err", 32'(rsp_err), 0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
